// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product coin-operated vending controller.
//
// Accepts Rs.5/10/20 coin pulses into a credit register capped at MAX_CREDIT,
// sells one of NUM_ITEMS products (price table PRICES, item i at bits
// [i*CREDIT_W +: CREDIT_W]) and pays change as a train of Rs.5 pulses.
//
// Optional feature macro: VM_STOCK_EN
//   defined   -> per-item stock counters start at STOCK_INIT; sold_out flags empty items
//   undefined -> unlimited sales, sold_out tied low
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   coin_5/coin_10/coin_20     one-cycle coin-inserted pulses
//   sel_valid, item_sel        one-cycle purchase request and item index
//   cancel                     one-cycle refund request (wins over sel_valid)
//   dispense, item_out         one-cycle product release and released item index
//   change_5                   one Rs.5 coin returned per high cycle
//   coin_reject                coin(s) from the previous cycle were not accepted
//   credit                     registered credit
//   busy                       dispensing or paying change
//   sold_out                   per-item empty flags
module vending_machine_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd10, 8'd25, 8'd20, 8'd15},
    parameter int MAX_CREDIT = 50,
    parameter int STOCK_INIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_5,
    input  logic                 coin_10,
    input  logic                 coin_20,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     item_sel,
    input  logic                 cancel,
    output logic                 dispense,
    output logic [SEL_W-1:0]     item_out,
    output logic                 change_5,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_CHANGE   = 2'd2;

    localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] COIN_STEP = CREDIT_W'(5);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] refund_q, refund_d;
    logic [SEL_W-1:0]    item_q, item_d;
    logic                reject_q, reject_d;

    logic                coin_any, coin_multi, coin_ok;
    logic [CREDIT_W-1:0] coin_val, credit_next, price_sel;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_known, sel_sold, sel_ok;

    always_comb begin
        coin_any   = coin_5 | coin_10 | coin_20;
        coin_multi = (coin_5 & coin_10) | (coin_5 & coin_20) | (coin_10 & coin_20);
        coin_val   = '0;
        if (coin_20)      coin_val = CREDIT_W'(20);
        else if (coin_10) coin_val = CREDIT_W'(10);
        else if (coin_5)  coin_val = CREDIT_W'(5);
        coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
        coin_ok     = coin_any && !coin_multi && (coin_sum <= MAX_C);
        credit_next = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;

        // Lookup by match so an out-of-range index never slices past the table.
        price_sel = '0;
        sel_known = 1'b0;
        sel_sold  = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel == SEL_W'(i)) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_known = 1'b1;
                sel_sold  = sold_out[i];
            end
        end
        sel_ok = sel_valid && sel_known && !sel_sold && (credit_next >= price_sel);
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        refund_d = refund_q;
        item_d   = item_q;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                reject_d = coin_any && !coin_ok;
                credit_d = credit_next;
                if (cancel) begin
                    credit_d = '0;
                    refund_d = credit_next;
                    if (credit_next != '0) state_d = ST_CHANGE;
                end else if (sel_ok) begin
                    credit_d = '0;
                    refund_d = credit_next - price_sel;
                    item_d   = item_sel;
                    state_d  = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                reject_d = coin_any;
                state_d  = (refund_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_d = coin_any;
                if (refund_q <= COIN_STEP) begin
                    refund_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    refund_d = refund_q - COIN_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            refund_q <= '0;
            item_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            refund_q <= refund_d;
            item_q   <= item_d;
            reject_q <= reject_d;
        end
    end

    assign dispense    = (state_q == ST_DISPENSE);
    assign change_5    = (state_q == ST_CHANGE);
    assign busy        = (state_q != ST_IDLE);
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign item_out    = item_q;

`ifdef VM_STOCK_EN
    localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i]  = stock_q[i];
            sold_out[i] = (stock_q[i] == '0);
            if (dispense && (item_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_RST;
        end else begin
            stock_q <= stock_d;
        end
    end
`else
    logic unused_stock_init;
    assign unused_stock_init = ^STOCK_INIT;
    assign sold_out = '0;
`endif

endmodule
